// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - multicycle RV32I control FSM with shared memory port
// Optional feature macro: ILLEGAL_TRAP_EN (unrecognised opcodes trap into a halt state).
// WAIT_LIMIT bounds cycles spent waiting on mem_ready; 0 means wait forever.
module rv32i_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       mem_err
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_ERROR    = 4'd11;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ILLEGAL  = 4'd12;
`endif

  // Counter only ever needs to reach WAIT_LIMIT-1 before the trip to ERROR.
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             waiting;
  logic             ready_eff;

  // ALU operation from funct3/funct7; op[5] separates R-type sub from I-type addi.
  function automatic logic [2:0] alu_decode(input logic op5, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] r;
    case (f3)
      3'b000:  r = (op5 & f7b5) ? 3'b001 : 3'b000;
      3'b010:  r = 3'b101;
      3'b100:  r = 3'b100;
      3'b110:  r = 3'b011;
      3'b111:  r = 3'b010;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // State, wait counter and sticky error register; reset parks everything in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic; memory-wait states bump the counter and may trip to ERROR.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    waiting    = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE; else waiting = 1'b1;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:                state_d = S_ILLEGAL;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB; else waiting = 1'b1;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH; else waiting = 1'b1;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`endif
      default: begin
        state_d   = S_FETCH;
        mem_err_d = 1'b0;
      end
    endcase
    if (waiting) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (WAIT_LIMIT > 0 && wait_cnt_q == LIMIT_M1) begin
        state_d    = S_ERROR;
        mem_err_d  = 1'b1;
        wait_cnt_d = '0;
      end
    end
  end

  // Datapath controls per state; ready is masked by reset so no strobe fires in reset.
  always_comb begin
    ready_eff  = mem_ready & reset;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = 3'b000;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready_eff;
        PCWrite   = ready_eff;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_ALUWB:   RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ImmSrc  = 2'b11;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero ^ funct3[0];
      end
      S_ERROR: ;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: ;
`endif
      default: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
    endcase
  end

  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - scoreboard bench for the multicycle control FSM
module tb_rv32i_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_err;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  rv32i_multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] val;
    logic [16:0] mask;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [16:0] M_PCW = 17'h10000, M_ADR = 17'h08000, M_MW = 17'h04000;
  localparam logic [16:0] M_IRW = 17'h02000, M_RW = 17'h01000, M_RS = 17'h00C00;
  localparam logic [16:0] M_SA = 17'h00300, M_SB = 17'h000C0, M_IMM = 17'h00030;
  localparam logic [16:0] M_ALU = 17'h0000E, M_ERR = 17'h00001;
  localparam logic [16:0] M_EN = M_PCW | M_MW | M_IRW | M_RW;

  logic [16:0] act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, mem_err};

  function automatic logic [16:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sbv,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic err);
    return {pcw, adr, mw, irw, rw, rs, sa, sbv, imm, alu, err};
  endfunction

  function automatic exp_t mk(input string n, input logic [16:0] v, input logic [16:0] m);
    exp_t e;
    e.val = v; e.mask = m; e.name = n;
    return e;
  endfunction

  function automatic exp_t e_reset();
    return mk("reset", pk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0),
              M_EN | M_ADR | M_RS | M_SA | M_SB | M_ERR);
  endfunction
  function automatic exp_t e_fetch(input logic r);
    return mk("fetch", pk(r,0,0,r,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 17'h1FFFF & ~M_IMM);
  endfunction
  function automatic exp_t e_decode();
    return mk("decode", pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0),
              M_EN | M_SA | M_SB | M_IMM | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_memadr(input logic [1:0] imm);
    return mk("memadr", pk(0,0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000,0),
              M_EN | M_SA | M_SB | M_IMM | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_memread();
    return mk("memread", pk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0),
              M_EN | M_ADR | M_RS | M_ERR);
  endfunction
  function automatic exp_t e_memwb();
    return mk("memwb", pk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0), M_EN | M_RS | M_ERR);
  endfunction
  function automatic exp_t e_memwrite();
    return mk("memwrite", pk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0),
              M_EN | M_ADR | M_RS | M_ERR);
  endfunction
  function automatic exp_t e_execr(input logic [2:0] alu);
    return mk("executer", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,alu,0),
              M_EN | M_SA | M_SB | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_execi(input logic [2:0] alu);
    return mk("executei", pk(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,alu,0),
              M_EN | M_SB | M_IMM | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_aluwb();
    return mk("aluwb", pk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), M_EN | M_RS | M_ERR);
  endfunction
  function automatic exp_t e_jal();
    return mk("jal", pk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0),
              M_EN | M_RS | M_SA | M_SB | M_IMM | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_branch(input logic p);
    return mk("branch", pk(p,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0),
              M_EN | M_RS | M_SA | M_SB | M_ALU | M_ERR);
  endfunction
  function automatic exp_t e_error();
    return mk("error", pk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), M_EN | M_ERR);
  endfunction
  function automatic exp_t e_halt();
    return mk("illegal", pk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), M_EN | M_ERR);
  endfunction

  // One clock cycle of stimulus: drive inputs, queue the expected outputs.
  task automatic cyc(input logic rst, input logic rdy, input logic z, input exp_t e);
    reset = rst; mem_ready = rdy; Zero = z;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (((act ^ e.val) & e.mask) != 17'h0) begin
        n_fail++;
        $display("FAIL %s @%0t: got %05h (masked %05h) expected %05h mask %05h",
                 e.name, $time, act, act & e.mask, e.val & e.mask, e.mask);
      end
    end
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
    instr(7'b0000000, 3'b000, 1'b0);
    @(posedge clk); #1;
    cyc(0, 1, 0, e_reset());
    cyc(0, 1, 0, e_reset());

    // lw x5,8(x0), memory always ready
    instr(7'b0000011, 3'b010, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_memadr(2'b00));
    cyc(1, 1, 0, e_memread());
    cyc(1, 1, 0, e_memwb());

    // lw with two wait cycles in MEMREAD
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_memadr(2'b00));
    cyc(1, 0, 0, e_memread());
    cyc(1, 0, 0, e_memread());
    cyc(1, 1, 0, e_memread());
    cyc(1, 1, 0, e_memwb());

    // sw with three not-ready cycles: MemWrite held four cycles
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_memadr(2'b01));
    cyc(1, 0, 0, e_memwrite());
    cyc(1, 0, 0, e_memwrite());
    cyc(1, 0, 0, e_memwrite());
    cyc(1, 1, 0, e_memwrite());

    // beq taken, bne not taken (Zero=1 both)
    instr(7'b1100011, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 1, e_branch(1));
    instr(7'b1100011, 3'b001, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 1, e_branch(0));

    // R-type sub, slt, or
    instr(7'b0110011, 3'b000, 1'b1);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_execr(3'b001));
    cyc(1, 1, 0, e_aluwb());
    instr(7'b0110011, 3'b010, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_execr(3'b101));
    cyc(1, 1, 0, e_aluwb());
    instr(7'b0110011, 3'b110, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_execr(3'b011));
    cyc(1, 1, 0, e_aluwb());

    // addi with funct7b5=1 stays add; xori
    instr(7'b0010011, 3'b000, 1'b1);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_execi(3'b000));
    cyc(1, 1, 0, e_aluwb());
    instr(7'b0010011, 3'b100, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_execi(3'b100));
    cyc(1, 1, 0, e_aluwb());

    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_jal());
    cyc(1, 1, 0, e_aluwb());

    // unrecognised opcode 0x7F
    instr(7'b1111111, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
`ifdef ILLEGAL_TRAP_EN
    cyc(1, 1, 0, e_halt());
    cyc(1, 1, 0, e_halt());
    cyc(1, 1, 0, e_halt());
`else
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
`endif
    cyc(0, 1, 0, e_reset());

    // reset asserted mid-MEMWRITE
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_memadr(2'b01));
    cyc(1, 0, 0, e_memwrite());
    cyc(0, 0, 0, e_reset());
    cyc(0, 1, 0, e_reset());
    cyc(1, 1, 0, e_fetch(1));
    cyc(1, 1, 0, e_decode());
    cyc(1, 1, 0, e_memadr(2'b01));
    cyc(1, 1, 0, e_memwrite());

    // wait-limit overflow in FETCH
    cyc(1, 0, 0, e_fetch(0));
    cyc(1, 0, 0, e_fetch(0));
    cyc(1, 0, 0, e_fetch(0));
    cyc(1, 0, 0, e_fetch(0));
    cyc(1, 1, 0, e_error());
    cyc(1, 1, 0, e_error());
    cyc(0, 1, 0, e_reset());
    cyc(1, 0, 0, e_fetch(0));
    cyc(1, 1, 0, e_fetch(1));

    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
